// File: rtl/aud_recorder_i2s.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aud_recorder_i2s : left-channel I2S capture to SRAM (WM8731 master, 16b)  |
// | Optional AUD_REC_PEAK_EN adds o_peak, the running peak |sample|.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aud_recorder_i2s #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned ADDR_MAX = 2**20-1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic              o_recording,
  output logic              o_full,
  output logic [ADDR_W:0]   o_len
`ifdef AUD_REC_PEAK_EN
  ,
  output logic [DATA_W-1:0] o_peak
`endif
);

  localparam int unsigned       C_CNT_W     = $clog2(DATA_W + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DATA_W);
  localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(ADDR_MAX);
  localparam logic [ADDR_W:0]   C_LEN_MAX   = (ADDR_W+1)'(ADDR_MAX) + (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_SHIFT  = 3'd2,
    S_WRITE  = 3'd3,
    S_PAUSED = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_lrc_d;
  logic                w_lrc_fall;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_len;
  logic                r_full;
  logic                r_pause_pend;

  // The cycle where LRC is first seen low carries the I2S delay bit.
  assign w_lrc_fall = r_lrc_d & ~i_lrc;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!i_stop && !i_pause && i_start) w_next = S_ARM;
      S_ARM: begin
        if (i_stop)          w_next = S_IDLE;
        else if (i_pause)    w_next = S_PAUSED;
        else if (w_lrc_fall) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_stop)                  w_next = S_IDLE;
        else if (r_cnt == C_CNT_LAST) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (r_addr == C_ADDR_LAST || i_stop) w_next = S_IDLE;
        else if (r_pause_pend || i_pause)    w_next = S_PAUSED;
        else                                 w_next = S_ARM;
      end
      S_PAUSED: begin
        if (i_stop)       w_next = S_IDLE;
        else if (i_pause) w_next = S_PAUSED;
        else if (i_start) w_next = S_ARM;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_lrc_d      <= 1'b1;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_full       <= 1'b0;
      r_pause_pend <= 1'b0;
    end else begin
      r_lrc_d <= i_lrc;
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_ARM) begin
            r_addr <= '0;
            r_len  <= '0;
            r_full <= 1'b0;
          end
        end
        S_ARM: begin
          if (w_next == S_SHIFT) begin
            r_cnt        <= '0;
            r_pause_pend <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_cnt != C_CNT_LAST) begin
            r_shift <= {r_shift[DATA_W-2:0], i_data};
            r_cnt   <= r_cnt + C_CNT_W'(1);
          end
          if (i_pause)            r_pause_pend <= 1'b1;
          if (w_next == S_WRITE)  r_data       <= r_shift;
        end
        S_WRITE: begin
          r_addr       <= r_addr + ADDR_W'(1);
          r_pause_pend <= 1'b0;
          if (r_len != C_LEN_MAX)     r_len  <= r_len + (ADDR_W+1)'(1);
          if (r_addr == C_ADDR_LAST)  r_full <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_address   = r_addr;
  assign o_data      = r_data;
  assign o_we        = (r_state == S_WRITE);
  assign o_recording = (r_state == S_ARM) || (r_state == S_SHIFT) || (r_state == S_WRITE);
  assign o_full      = r_full;
  assign o_len       = r_len;

`ifdef AUD_REC_PEAK_EN
  logic [DATA_W-1:0] r_peak;
  logic [DATA_W-1:0] w_abs;

  // Most negative code has no positive twin, so it clamps to the largest positive.
  always_comb begin
    w_abs = r_data;
    if (r_data[DATA_W-1]) begin
      if (r_data == {1'b1, {(DATA_W-1){1'b0}}}) w_abs = {1'b0, {(DATA_W-1){1'b1}}};
      else                                      w_abs = ~r_data + DATA_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_peak <= '0;
    end else if (r_state == S_IDLE && w_next == S_ARM) begin
      r_peak <= '0;
    end else if (r_state == S_WRITE && w_abs > r_peak) begin
      r_peak <= w_abs;
    end
  end

  assign o_peak = r_peak;
`else
  // Peak tracking is absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_aud_recorder_i2s.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aud_recorder_i2s : scoreboard bench for aud_recorder_i2s (ADDR_MAX=3)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_aud_recorder_i2s;
  localparam int DW = 16;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst, start, pause, stop, lrc, din;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          we, rec, full;
  logic [AW:0]   len;
`ifdef AUD_REC_PEAK_EN
  logic [DW-1:0] peak;
`endif

  always #5 clk = ~clk;

  aud_recorder_i2s #(.DATA_W(DW), .ADDR_W(AW), .ADDR_MAX(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_lrc(lrc), .i_data(din), .o_address(addr), .o_data(dout), .o_we(we),
    .o_recording(rec), .o_full(full), .o_len(len)
`ifdef AUD_REC_PEAK_EN
    , .o_peak(peak)
`endif
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   c;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (we === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_we", {31'b0, we}, 32'h0);
      end else begin
        e = q.pop_front();
        check("wr_addr", 32'(addr), 32'(e.a));
        check("wr_data", 32'(dout), 32'(e.d));
        check("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      lrc = 1'b1; din = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  // One 32-BCLK frame: delay bit, left sample MSB first, then right slot of ones.
  task automatic frame(input logic [DW-1:0] s, input bit wr, input logic [AW-1:0] a,
                       input int pause_k, input int stop_k);
    logic [31:0] bits;
    bits = {1'b1, s, 15'h7FFF};
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (stop_k >= 0 && k == stop_k + 1) check("stop_rec", {31'b0, rec}, 32'h0);
      lrc   = (k >= 16);
      din   = bits[31-k];
      pause = (k == pause_k);
      stop  = (k == stop_k);
      // LRC fall seen at the coming edge; the strobe shows 17 edges later.
      if (k == 0 && wr) q.push_back('{a: a, d: s, c: cyc + 18});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; lrc = 1'b1; din = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_data", 32'(dout), 32'h0);
    check("rst_we",   {31'b0, we},  32'h0);
    check("rst_rec",  {31'b0, rec}, 32'h0);
    check("rst_full", {31'b0, full}, 32'h0);
    check("rst_len",  32'(len), 32'h0);
`ifdef AUD_REC_PEAK_EN
    check("rst_peak", 32'(peak), 32'h0);
`endif
    rst = 1'b0;

    // No start: frames must not produce writes.
    frame(16'h5A5A, 1'b0, '0, -1, -1);
    frame(16'hA5A5, 1'b0, '0, -1, -1);
    check("idle_rec", {31'b0, rec}, 32'h0);
    check("idle_len", 32'(len), 32'h0);

    // Basic capture of three samples.
    pulse_start();
    check("start_rec", {31'b0, rec}, 32'h1);
    frame(16'h8001, 1'b1, 20'd0, -1, -1);
    frame(16'h1234, 1'b1, 20'd1, -1, -1);
    frame(16'h7FFF, 1'b1, 20'd2, -1, -1);
    idle(2);
    pulse_stop();
    check("t2_len", 32'(len), 32'd3);
    check("t2_rec", {31'b0, rec}, 32'h0);

    // Pause mid-sample: sample still written, then paused, then resume.
    pulse_start();
    frame(16'h00AA, 1'b1, 20'd0, 5, -1);
    check("pause_rec", {31'b0, rec}, 32'h0);
    frame(16'h5555, 1'b0, '0, -1, -1);
    frame(16'h5555, 1'b0, '0, -1, -1);
    pulse_start();
    frame(16'h0BCD, 1'b1, 20'd1, -1, -1);
    check("t3_len", 32'(len), 32'd2);

    // Stop at bit 7: partial sample dropped.
    frame(16'h3C3C, 1'b0, '0, -1, 9);
    check("t4_len",  32'(len), 32'd2);
    check("t4_addr", 32'(addr), 32'd2);
    check("t4_rec",  {31'b0, rec}, 32'h0);

    // Fill to the last address.
    pulse_start();
    check("t5_len0",  32'(len), 32'd0);
    check("t5_addr0", 32'(addr), 32'd0);
    for (int i = 0; i < 4; i++) frame(16'(16'h1111 * (i + 1)), 1'b1, 20'(i), -1, -1);
    check("full_set", {31'b0, full}, 32'h1);
    check("full_len", 32'(len), 32'd4);
    check("full_rec", {31'b0, rec}, 32'h0);
    frame(16'h9999, 1'b0, '0, -1, -1);
    frame(16'hAAAA, 1'b0, '0, -1, -1);
    check("full_hold", {31'b0, full}, 32'h1);
    pulse_start();
    check("full_clr", {31'b0, full}, 32'h0);
    check("len_clr",  32'(len), 32'd0);

    // Peak tracking samples.
    frame(16'h0100, 1'b1, 20'd0, -1, -1);
`ifdef AUD_REC_PEAK_EN
    check("peak_0100", 32'(peak), 32'h0100);
`endif
    frame(16'hFF00, 1'b1, 20'd1, -1, -1);
`ifdef AUD_REC_PEAK_EN
    check("peak_ff00", 32'(peak), 32'h0100);
`endif
    frame(16'h8000, 1'b1, 20'd2, -1, -1);
`ifdef AUD_REC_PEAK_EN
    check("peak_8000", 32'(peak), 32'h7FFF);
`endif
    pulse_stop();
    check("t6_len", 32'(len), 32'd3);

    idle(4);
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
